seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring divider/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the inverse counterpart of the combinational add/sub datapath: it uses repeated N-bit subtraction and produces one quotient bit per cycle.
- It sits beside the ALU in the EX stage. The pipeline holds the stage while busy=1 and captures result when done=1.

Parameters:
- N, 32, operand/result width in bits (N ≥ 4).
- CW, 6, width of the iteration counter; must satisfy 2^CW > N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  funct3[1:0] encoding: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  N  rs1 value.
- divisor  input  N  rs2 value.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse marking result valid.
- result  output  N  quotient or remainder, selected by op.

Behaviour:
- One clock (clk). rst is synchronous and active-high. On rst: state=IDLE, busy=0, done=0, result=0, all internal registers=0.
- States: IDLE, CALC, FIN.
- IDLE:
  - If start=1, latch op, dividend and divisor. Do not sample start in any other state; start while busy is ignored and not queued.
  - Divisor == 0: go to FIN directly. Quotient = all ones; remainder = dividend, unchanged and unsigned-interpreted.
  - Signed op with dividend == 2^(N-1) and divisor == all ones: go to FIN directly. Quotient = 2^(N-1); remainder = 0.
  - Otherwise: take magnitudes (two's complement negate if op is signed and MSB=1). Record qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend). Clear the N+1-bit partial remainder R, load Q with the dividend magnitude, set count=0, go to CALC.
- CALC, one step per cycle:
  - R' = {R[N-1:0], Q[N-1]}; diff = R' − {0, |divisor|}.
  - If diff[N] == 0: R ← diff and Q ← {Q[N-2:0], 1}. Else: R ← R' and Q ← {Q[N-2:0], 0}.
  - count increments. After the step where count == N-1, go to FIN.
- FIN, one cycle:
  - done=1. result = quotient (negated if qneg) for DIV/DIVU, or remainder (negated if rneg) for REM/REMU. Unsigned ops apply no negation.
  - Next state is IDLE. A start in the FIN cycle is ignored.
- Timing, with start sampled in cycle T:
  - Normal operation: busy=1 for cycles T+1..T+N+1 (CALC plus FIN); done=1 in cycle T+N+1 only. This is N+1 cycles of latency; 33 for N=32.
  - Special cases: busy=1 and done=1 in cycle T+1 only.
- busy = (state != IDLE). done = (state == FIN).
- result holds its last value in IDLE until the next FIN writes it.
- Signed results are two's complement and wrap modulo 2^N. Truncation is toward zero. The remainder sign follows the dividend.
- rst asserted mid-operation aborts at the next edge: IDLE, busy=0, done=0, result=0.

Optional Feature:
- SEQ_DIVIDER_FLUSH_EN.
- When defined: adds port flush (input, 1, after start). flush=1 in CALC or FIN returns to IDLE at the next edge. done is suppressed in that cycle if in FIN. result is not updated. flush has priority over the FIN→IDLE update, and is ignored in IDLE (start still wins there).
- When undefined: no flush port; an operation always runs to completion unless rst is asserted.

Test Plan:
- DIVU 100/7, start in T → busy T+1..T+33, done only at T+33, result=14; repeat as REMU → result=2.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD(−3); REM same operands → 0xFFFFFFFF(−1). REM 7/0xFFFFFFFE(−2) → 1.
- DIVU 0x12345678/0 → 0xFFFFFFFF; REM 0x12345678/0 → 0x12345678. Both: done at T+1, busy only at T+1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; done at T+1.
- Start DIVU 50/5, re-pulse start with 9/3 at T+5 → ignored, result=10 at T+33. Assert rst at T+10 → busy=0 and result=0 at T+11, no done.
- With SEQ_DIVIDER_FLUSH_EN: flush at T+20 → IDLE at T+21, no done, result keeps its prior value. A new start at T+22 completes normally.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle. Latency is N+1 cycles, or 1 cycle for divide-by-zero
// and signed overflow.
// Optional macro SEQ_DIVIDER_FLUSH_EN adds a flush input that aborts CALC/FIN.
module seq_divider #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SEQ_DIVIDER_FLUSH_EN
    input  logic         flush,
`endif
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state;
    logic           sel_rem;   // 1: REM/REMU, 0: DIV/DIVU
    logic           qneg, rneg;
    logic [N-1:0]   rem;       // partial remainder, always < divisor, so its top bit is never needed
    logic [N-1:0]   quo;       // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]   dvsr;
    logic [N-1:0]   res_r;
    logic [CW-1:0]  count;
    logic           flush_i;

`ifdef SEQ_DIVIDER_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // operand decode used when a request is accepted in IDLE
    logic           is_signed, a_neg, b_neg, div_zero, ovf;
    logic [N-1:0]   a_mag, b_mag;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[N-1];
    assign b_neg     = is_signed & divisor[N-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor  : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // one restoring step: shift in next dividend bit, trial subtract
    logic [N:0]     r_sh, diff;
    assign r_sh = {rem, quo[N-1]};
    assign diff = r_sh - {1'b0, dvsr};

    // signed fix-up of the final quotient or remainder
    logic [N-1:0]   fin_val;
    assign fin_val = sel_rem ? (rneg ? -rem : rem) : (qneg ? -quo : quo);

    assign busy   = (state != IDLE);
    assign done   = (state == FIN) && !flush_i;
    // the FIN value is presented while done is high and committed on leaving FIN,
    // so a flush in FIN leaves the held result untouched
    assign result = done ? fin_val : res_r;

    // control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_rem <= 1'b0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            res_r   <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_rem <= op[1];
                        count   <= '0;
                        dvsr    <= b_mag;
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= dividend;
                            qneg  <= 1'b0;
                            rneg  <= 1'b0;
                            state <= FIN;
                        end else if (ovf) begin
                            quo   <= MIN_NEG;
                            rem   <= '0;
                            qneg  <= 1'b0;
                            rneg  <= 1'b0;
                            state <= FIN;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            qneg  <= a_neg ^ b_neg;
                            rneg  <= a_neg;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        if (!diff[N]) begin
                            rem <= diff[N-1:0];
                            quo <= {quo[N-2:0], 1'b1};
                        end else begin
                            rem <= r_sh[N-1:0];
                            quo <= {quo[N-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(N-1))
                            state <= FIN;
                    end
                end
                FIN: begin
                    if (!flush_i)
                        res_r <= fin_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors, scoreboard queue checked by a done monitor.
module tb_seq_divider;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef SEQ_DIVIDER_FLUSH_EN
    logic          flush;
`endif
    logic [1:0]    op;
    logic [N-1:0]  dividend, divisor;
    logic          busy, done;
    logic [N-1:0]  result;

    seq_divider #(.N(N), .CW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SEQ_DIVIDER_FLUSH_EN
        .flush    (flush),
`endif
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];
    int           cyc_q[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                logic [N-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("result", result, e);
                check("done_cycle", N'(cyc), N'(ec));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    // issue one op, expect done after lat cycles, check busy window
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input int lat);
        int t;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        t = cyc;
        exp_q.push_back(exp);
        cyc_q.push_back(t + lat);
        @(negedge clk);
        start = 1'b0;
        check("busy_first", N'(busy), N'(1));
        repeat (lat - 1) @(negedge clk);
        check("busy_last", N'(busy), N'(1));
        @(negedge clk);
        check("busy_after", N'(busy), N'(0));
    endtask

    initial begin
        int t;
        logic [N-1:0] prior;
        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", N'(busy), N'(0));
        check("rst_done", N'(done), N'(0));
        check("rst_result", result, '0);
        rst = 1'b0;

        // normal ops: 33-cycle latency
        run_op(2'b01, 32'd100,        32'd7,          32'd14,        33);
        run_op(2'b11, 32'd100,        32'd7,          32'd2,         33);
        run_op(2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,  33);
        run_op(2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,  33);
        run_op(2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,         33);
        run_op(2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,  33);
        run_op(2'b00, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,         33);
        run_op(2'b10, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'hFFFFFFFE,  33);
        run_op(2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,  33);
        run_op(2'b11, 32'hFFFFFFFF,   32'h10,         32'h0000000F,  33);
        run_op(2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,         33);
        run_op(2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,  33);

        // special cases: one cycle
        run_op(2'b01, 32'h12345678,   32'd0,          32'hFFFFFFFF,  1);
        run_op(2'b10, 32'h12345678,   32'd0,          32'h12345678,  1);
        run_op(2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,  1);
        run_op(2'b00, 32'd0,          32'd0,          32'hFFFFFFFF,  1);
        run_op(2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,  1);
        run_op(2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,         1);

        // start re-pulsed while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        t = cyc;
        exp_q.push_back(32'd10);
        cyc_q.push_back(t + 33);
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 5) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 34) @(negedge clk);
        check("repulse_idle", N'(busy), N'(0));
        check("repulse_held", result, 32'd10);

`ifdef SEQ_DIVIDER_FLUSH_EN
        // flush mid-CALC: no done, result keeps prior value, next op normal
        prior = result;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 20) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", N'(busy), N'(0));
        check("flush_done", N'(done), N'(0));
        check("flush_result", result, prior);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 33);
`endif

        // reset mid-operation aborts with no done
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", N'(busy), N'(0));
        check("abort_done", N'(done), N'(0));
        check("abort_result", result, '0);
        repeat (30) @(negedge clk);
        check("abort_still_idle", N'(busy), N'(0));

        check("scoreboard_drained", N'(exp_q.size()), N'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
